multiply_sequencer: RTL and testbench

- Sequences one signed 4-bit × 4-bit multiply for the calculator datapath.
- Drives the two's-complement unit to get operand magnitudes, runs an unsigned shift-add core, then re-applies the result sign.
- Owns the clear/request/wait handshake with the complement unit. That unit's finish flag is sticky until its reset, so this block must clear it before each use.
- Sits between the operand decode stage and the result/display stage.

---
 rtl/multiply_seq_pkg.sv | 17 +
 rtl/mult_shift_add_core.sv | 49 ++++
 rtl/multiply_sequencer.sv | 144 ++++++++++++++
 tb/tb_multiply_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/multiply_seq_pkg.sv
// Shared types and defaults for the signed 4x4 multiply sequencer.
package multiply_seq_pkg;

  localparam int unsigned W_DEFAULT       = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    REQ      = 3'd2,
    WAIT_CPL = 3'd3,
    MUL      = 3'd4,
    FIX      = 3'd5,
    ERR      = 3'd6
  } state_t;

endpackage

// File: rtl/mult_shift_add_core.sv
// Unsigned W x W shift-add multiplier. One partial product is added per cycle
// after load. last is high during the cycle that performs the final step.
module mult_shift_add_core
  import multiply_seq_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [W-1:0]   mag_a,
  input  logic [W-1:0]   mag_b,
  output logic [2*W-1:0] acc,
  output logic           last
);

  localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;

  logic [2*W-1:0] a_sh;
  logic [W-1:0]   b_sh;
  logic [BW-1:0]  bit_cnt;
  logic           run;

  assign last = run && (bit_cnt == BW'(W - 1));

  // Load operands, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      bit_cnt <= '0;
      run     <= 1'b0;
    end else if (load) begin
      acc     <= '0;
      a_sh    <= {{W{1'b0}}, mag_a};
      b_sh    <= mag_b;
      bit_cnt <= '0;
      run     <= 1'b1;
    end else if (run) begin
      if (b_sh[0]) acc <= acc + a_sh;
      a_sh    <= a_sh << 1;
      b_sh    <= b_sh >> 1;
      bit_cnt <= bit_cnt + BW'(1);
      if (last) run <= 1'b0;
    end
  end

endmodule

// File: rtl/multiply_sequencer.sv
// Signed W x W multiply sequencer: obtains operand magnitudes from the external
// two's-complement unit (clear, request, wait with timeout), runs the unsigned
// shift-add core, then restores the product sign.
module multiply_sequencer
  import multiply_seq_pkg::*;
#(
  parameter int unsigned W       = W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   first_nr,
  input  logic [W-1:0]   second_nr,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [2*W-1:0] product,
  output logic           cpl_clr,
  output logic           cpl_sel,
  output logic [W-1:0]   cpl_a,
  output logic [W-1:0]   cpl_b,
  input  logic [W-1:0]   cpl_first,
  input  logic [W-1:0]   cpl_second,
  input  logic           cpl_finish
);

  state_t         state;
  logic           sign_a;
  logic           sign_b;
  logic           neg;
  logic [CNT_W-1:0] wait_cnt;

  logic           start_neg;
  logic           core_load;
  logic [W-1:0]   core_mag_a;
  logic [W-1:0]   core_mag_b;
  logic [2*W-1:0] core_acc;
  logic           core_last;

  assign start_neg = first_nr[W-1] | second_nr[W-1];

  // Magnitudes go to the core straight from the operands when both are
  // non-negative, otherwise from the complement unit as it reports finish.
  always_comb begin
    core_load  = 1'b0;
    core_mag_a = sign_a ? cpl_first  : cpl_a;
    core_mag_b = sign_b ? cpl_second : cpl_b;
    if (state == IDLE) begin
      core_mag_a = first_nr;
      core_mag_b = second_nr;
      core_load  = start && !start_neg;
    end else if (state == WAIT_CPL) begin
      core_load  = cpl_finish;
    end
  end

  mult_shift_add_core #(.W(W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (core_load),
    .mag_a (core_mag_a),
    .mag_b (core_mag_b),
    .acc   (core_acc),
    .last  (core_last)
  );

  // Sequencer FSM; all outputs are registered and pulses last one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      neg      <= 1'b0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      product  <= '0;
      cpl_clr  <= 1'b0;
      cpl_sel  <= 1'b0;
      cpl_a    <= '0;
      cpl_b    <= '0;
    end else begin
      done    <= 1'b0;
      cpl_clr <= 1'b0;
      cpl_sel <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cpl_a  <= first_nr;
            cpl_b  <= second_nr;
            error  <= 1'b0;
            sign_a <= first_nr[W-1];
            sign_b <= second_nr[W-1];
            neg    <= first_nr[W-1] ^ second_nr[W-1];
            busy   <= 1'b1;
            if (start_neg) begin
              cpl_clr <= 1'b1;
              state   <= CLEAR;
            end else begin
              state   <= MUL;
            end
          end
        end
        CLEAR: begin
          cpl_sel <= 1'b1;
          state   <= REQ;
        end
        REQ: begin
          wait_cnt <= '0;
          state    <= WAIT_CPL;
        end
        WAIT_CPL: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (cpl_finish)                          state <= MUL;
          else if (wait_cnt == CNT_W'(TIMEOUT))    state <= ERR;
        end
        MUL: begin
          if (core_last) state <= FIX;
        end
        FIX: begin
          product <= neg ? (~core_acc + (2*W)'(1)) : core_acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        ERR: begin
          product <= '0;
          error   <= 1'b1;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiply_sequencer.sv
// Directed bench for multiply_sequencer with a behavioural complement unit.
module tb_multiply_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] first_nr, second_nr;
  logic       busy, done, error;
  logic [7:0] product;
  logic       cpl_clr, cpl_sel;
  logic [3:0] cpl_a, cpl_b;
  logic [3:0] cpl_first  = 4'd0;
  logic [3:0] cpl_second = 4'd0;
  logic       cpl_finish = 1'b0;

  int checks   = 0;
  int failures = 0;

  // complement unit model state
  logic resp_en = 1'b1;
  int   dly     = 0;
  // event bookkeeping
  int   cyc = 0, clr_cyc = 0, sel_cyc = 0;
  int   clr_cnt = 0, sel_cnt = 0, done_cnt = 0;

  multiply_sequencer #(.W(4), .TIMEOUT(15), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_nr   (first_nr),
    .second_nr  (second_nr),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .product    (product),
    .cpl_clr    (cpl_clr),
    .cpl_sel    (cpl_sel),
    .cpl_a      (cpl_a),
    .cpl_b      (cpl_b),
    .cpl_first  (cpl_first),
    .cpl_second (cpl_second),
    .cpl_finish (cpl_finish)
  );

  always #5 clk = ~clk;

  // Complement unit: finish is sticky until clr, raised two cycles after sel.
  always @(posedge clk) begin
    if (cpl_clr) begin
      cpl_finish <= 1'b0;
      dly        <= 0;
    end else if (cpl_sel && resp_en) begin
      cpl_first  <= (~cpl_a) + 4'd1;
      cpl_second <= (~cpl_b) + 4'd1;
      dly        <= 2;
    end else if (dly != 0) begin
      dly <= dly - 1;
      if (dly == 1) cpl_finish <= 1'b1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cpl_clr) begin clr_cyc <= cyc; clr_cnt <= clr_cnt + 1; end
    if (cpl_sel) begin sel_cyc <= cyc; sel_cnt <= sel_cnt + 1; end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output logic timed_out);
    @(negedge clk);
    first_nr = a; second_nr = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0; timed_out = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = n; timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; first_nr = 4'd0; second_nr = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)    begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (error !== 1'b0)   begin failures++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (product !== 8'h00) begin failures++; $display("FAIL reset_product: got %h expected 00", product); end
    checks++; if (cpl_clr !== 1'b0) begin failures++; $display("FAIL reset_cpl_clr: got %b expected 0", cpl_clr); end
    checks++; if (cpl_sel !== 1'b0) begin failures++; $display("FAIL reset_cpl_sel: got %b expected 0", cpl_sel); end
    checks++; if (cpl_a !== 4'h0)   begin failures++; $display("FAIL reset_cpl_a: got %h expected 0", cpl_a); end
    checks++; if (cpl_b !== 4'h0)   begin failures++; $display("FAIL reset_cpl_b: got %h expected 0", cpl_b); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_unsigned;
    int lat; logic to; int s0, c0;
    s0 = sel_cnt; c0 = clr_cnt;
    run_op(4'b0011, 4'b0101, lat, to);
    checks++; if (to !== 1'b0)      begin failures++; $display("FAIL pos_timeout: got %b expected 0", to); end
    checks++; if (lat != 5)         begin failures++; $display("FAIL pos_latency: got %0d expected 5", lat); end
    checks++; if (product !== 8'h0F) begin failures++; $display("FAIL pos_product: got %h expected 0f", product); end
    checks++; if (error !== 1'b0)   begin failures++; $display("FAIL pos_error: got %b expected 0", error); end
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL pos_busy: got %b expected 0", busy); end
    checks++; if (sel_cnt != s0)    begin failures++; $display("FAIL pos_no_sel: got %0d expected %0d", sel_cnt, s0); end
    checks++; if (clr_cnt != c0)    begin failures++; $display("FAIL pos_no_clr: got %0d expected %0d", clr_cnt, c0); end
  endtask

  task automatic test_neg_one;
    int lat; logic to; int s0, c0;
    s0 = sel_cnt; c0 = clr_cnt;
    run_op(4'b1101, 4'b0101, lat, to);
    checks++; if (to !== 1'b0)        begin failures++; $display("FAIL neg_timeout: got %b expected 0", to); end
    checks++; if (lat != 10)          begin failures++; $display("FAIL neg_latency: got %0d expected 10", lat); end
    checks++; if (product !== 8'hF1)  begin failures++; $display("FAIL neg_product: got %h expected f1", product); end
    checks++; if (error !== 1'b0)     begin failures++; $display("FAIL neg_error: got %b expected 0", error); end
    checks++; if (cpl_a !== 4'b1101)  begin failures++; $display("FAIL neg_cpl_a: got %b expected 1101", cpl_a); end
    checks++; if (clr_cnt != c0 + 1)  begin failures++; $display("FAIL neg_clr_count: got %0d expected %0d", clr_cnt, c0 + 1); end
    checks++; if (sel_cnt != s0 + 1)  begin failures++; $display("FAIL neg_sel_count: got %0d expected %0d", sel_cnt, s0 + 1); end
    checks++; if (sel_cyc != clr_cyc + 1) begin failures++; $display("FAIL neg_clr_then_sel: got sel@%0d expected clr@%0d+1", sel_cyc, clr_cyc); end
  endtask

  task automatic test_corners;
    int lat; logic to;
    run_op(4'b1000, 4'b1000, lat, to);
    checks++; if (to !== 1'b0)       begin failures++; $display("FAIL m8m8_timeout: got %b expected 0", to); end
    checks++; if (product !== 8'h40) begin failures++; $display("FAIL m8m8_product: got %h expected 40", product); end
    run_op(4'b0000, 4'b1111, lat, to);
    checks++; if (to !== 1'b0)       begin failures++; $display("FAIL zero_neg_timeout: got %b expected 0", to); end
    checks++; if (product !== 8'h00) begin failures++; $display("FAIL zero_neg_product: got %h expected 00", product); end
  endtask

  task automatic test_stale_finish;
    int lat; logic to; int c0;
    run_op(4'b1111, 4'b0001, lat, to);
    checks++; if (product !== 8'hFF) begin failures++; $display("FAIL stale_first_product: got %h expected ff", product); end
    c0 = clr_cnt;
    run_op(4'b1110, 4'b0011, lat, to);
    checks++; if (to !== 1'b0)       begin failures++; $display("FAIL stale_timeout: got %b expected 0", to); end
    checks++; if (product !== 8'hFA) begin failures++; $display("FAIL stale_product: got %h expected fa", product); end
    checks++; if (clr_cnt != c0 + 1) begin failures++; $display("FAIL stale_clr_count: got %0d expected %0d", clr_cnt, c0 + 1); end
    checks++; if (!(clr_cyc < sel_cyc)) begin failures++; $display("FAIL stale_clr_before_sel: got clr@%0d sel@%0d expected clr first", clr_cyc, sel_cyc); end
  endtask

  task automatic test_timeout;
    int lat; logic to;
    resp_en = 1'b0;
    run_op(4'b1111, 4'b0010, lat, to);
    checks++; if (to !== 1'b0)       begin failures++; $display("FAIL tmo_done_seen: got %b expected 0", to); end
    checks++; if (error !== 1'b1)    begin failures++; $display("FAIL tmo_error: got %b expected 1", error); end
    checks++; if (product !== 8'h00) begin failures++; $display("FAIL tmo_product: got %h expected 00", product); end
    checks++; if (lat < 17)          begin failures++; $display("FAIL tmo_latency: got %0d expected >= 17", lat); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (error !== 1'b1)    begin failures++; $display("FAIL tmo_error_held: got %b expected 1", error); end
    resp_en = 1'b1;
    run_op(4'b0010, 4'b0011, lat, to);
    checks++; if (error !== 1'b0)    begin failures++; $display("FAIL tmo_error_cleared: got %b expected 0", error); end
    checks++; if (product !== 8'h06) begin failures++; $display("FAIL tmo_recover_product: got %h expected 06", product); end
  endtask

  task automatic test_busy_start;
    int d0;
    @(negedge clk);
    first_nr = 4'b1101; second_nr = 4'b0101; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    first_nr = 4'b0111; second_nr = 4'b0111; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (done_cnt != d0 + 1)  begin failures++; $display("FAIL busy_single_done: got %0d expected %0d", done_cnt, d0 + 1); end
    checks++; if (product !== 8'hF1)   begin failures++; $display("FAIL busy_product: got %h expected f1", product); end
    checks++; if (cpl_a !== 4'b1101)   begin failures++; $display("FAIL busy_cpl_a_stable: got %b expected 1101", cpl_a); end
  endtask

  task automatic test_reset_mid_mul;
    int d0; int lat; logic to;
    @(negedge clk);
    first_nr = 4'b0011; second_nr = 4'b0101; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    checks++; if (product !== 8'h00) begin failures++; $display("FAIL rmid_product: got %h expected 00", product); end
    checks++; if (cpl_a !== 4'h0)    begin failures++; $display("FAIL rmid_cpl_a: got %h expected 0", cpl_a); end
    checks++; if (cpl_b !== 4'h0)    begin failures++; $display("FAIL rmid_cpl_b: got %h expected 0", cpl_b); end
    checks++; if (done !== 1'b0)     begin failures++; $display("FAIL rmid_done: got %b expected 0", done); end
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (done_cnt != d0)    begin failures++; $display("FAIL rmid_no_done: got %0d expected %0d", done_cnt, d0); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL rmid_idle_busy: got %b expected 0", busy); end
    run_op(4'b0011, 4'b0101, lat, to);
    checks++; if (product !== 8'h0F) begin failures++; $display("FAIL rmid_recover_product: got %h expected 0f", product); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_neg_one();
    test_corners();
    test_stale_finish();
    test_timeout();
    test_busy_start();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
